// File: rtl/board_row_fetch_arbiter.sv
// Round-robin arbiter sharing one GameBoard wall-map ROM port among maze agents.
// Each grant issues a locked three-read burst (row-1, row, row+1) and returns
// every row tagged with the requester index and row kind.
module board_row_fetch_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ROW_W    = 5,
    parameter int ROW_BITS = 21,
    parameter int ROM_LAT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ROW_W-1:0] req_row,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ROW_W-1:0]         rom_addr,
    input  logic [ROW_BITS-1:0]      rom_q,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_id,
    output logic [1:0]               rsp_kind,
    output logic [ROW_BITS-1:0]      rsp_data,
    output logic [NUM_REQ-1:0]       done
);

    typedef enum logic [1:0] {IDLE, UP, MID, DN} state_t;

    localparam logic [1:0]       KIND_UP  = 2'd0;
    localparam logic [1:0]       KIND_MID = 2'd1;
    localparam logic [1:0]       KIND_DN  = 2'd2;
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t                  state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic [2:0]              cur_id_q, cur_id_d;
    logic [ROW_W-1:0]        cur_row_q, cur_row_d;
    logic [ROM_LAT-1:0]      pipe_valid_q, pipe_valid_d;
    logic [ROM_LAT-1:0][2:0] pipe_id_q, pipe_id_d;
    logic [ROM_LAT-1:0][1:0] pipe_kind_q, pipe_kind_d;

    logic       grant_window;
    logic       pick_found;
    logic [2:0] pick_id;
    int         scan_idx;

    // Find the first requesting agent at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 3'd0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = 3'(scan_idx);
            end
        end
    end

    // Grants are only offered between bursts (IDLE) or on the last read (DN).
    always_comb begin
        grant_window = !reset && ((state_q == IDLE) || (state_q == DN));
        gnt = '0;
        if (grant_window && pick_found) begin
            gnt[pick_id] = 1'b1;
        end
    end

    // Burst sequencing: latch the winner's row, then walk UP, MID, DN.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_id_d  = cur_id_q;
        cur_row_d = cur_row_q;
        unique case (state_q)
            IDLE, DN: begin
                if (grant_window && pick_found) begin
                    state_d   = UP;
                    cur_id_d  = pick_id;
                    cur_row_d = req_row[int'(pick_id)*ROW_W +: ROW_W];
                    rr_ptr_d  = (pick_id == 3'(NUM_REQ-1)) ? 3'd0 : pick_id + 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            UP:      state_d = MID;
            MID:     state_d = DN;
            default: state_d = IDLE;
        endcase
    end

    // ROM address follows the burst phase; row arithmetic wraps modulo 2^ROW_W.
    always_comb begin
        unique case (state_q)
            UP:      rom_addr = cur_row_q - ROW_ONE;
            MID:     rom_addr = cur_row_q;
            DN:      rom_addr = cur_row_q + ROW_ONE;
            default: rom_addr = cur_row_q;
        endcase
    end

    // Tag pipeline that lines up {valid, id, kind} with the ROM read latency.
    always_comb begin
        pipe_valid_d   = pipe_valid_q;
        pipe_id_d      = pipe_id_q;
        pipe_kind_d    = pipe_kind_q;
        pipe_valid_d[0] = (state_q != IDLE);
        pipe_id_d[0]    = cur_id_q;
        unique case (state_q)
            MID:     pipe_kind_d[0] = KIND_MID;
            DN:      pipe_kind_d[0] = KIND_DN;
            default: pipe_kind_d[0] = KIND_UP;
        endcase
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_id_d[i]    = pipe_id_q[i-1];
            pipe_kind_d[i]  = pipe_kind_q[i-1];
        end
    end

    // Response outputs come from the pipeline tail; data passes straight through.
    always_comb begin
        rsp_valid = pipe_valid_q[ROM_LAT-1];
        rsp_id    = pipe_id_q[ROM_LAT-1];
        rsp_kind  = pipe_kind_q[ROM_LAT-1];
        rsp_data  = rom_q;
        done      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            done[i] = rsp_valid && (rsp_kind == KIND_DN) && (rsp_id == 3'(i));
        end
    end

    // State registers with synchronous reset that also abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 3'd0;
            cur_id_q     <= 3'd0;
            cur_row_q    <= '0;
            pipe_valid_q <= '0;
            pipe_id_q    <= '0;
            pipe_kind_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_id_q     <= cur_id_d;
            cur_row_q    <= cur_row_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            pipe_kind_q  <= pipe_kind_d;
        end
    end

endmodule
